nand_self_test: RTL

NAND_SELF_TEST -- requirements
Module: nand_self_test

---
 rtl/nand_self_test.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nand_self_test.sv
// Built-in self test for an external 8-lane NAND: LFSR-generated operands are applied,
// allowed to settle, and the returned result is compared lane by lane against an ideal NAND.
module nand_self_test #(
  parameter int unsigned VEC_COUNT = 256,
  parameter int unsigned SETTLE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  dut_a,
  output logic [7:0]  dut_b,
  input  logic [7:0]  dut_y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] fail_idx
);

  localparam logic [15:0] SEED        = 16'hACE1;
  localparam logic [15:0] NO_FAIL     = 16'hFFFF;
  localparam logic [15:0] LAST_IDX    = 16'(VEC_COUNT - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  dut_a_q, dut_a_d;
  logic [7:0]  dut_b_q, dut_b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] fail_q, fail_d;
  logic        mismatch_s;
  logic [15:0] lfsr_next_s;

  assign mismatch_s  = (dut_y != ~(dut_a_q & dut_b_q));
  assign lfsr_next_s = lfsr_step(lfsr_q);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    dut_a_d  = dut_a_q;
    dut_b_d  = dut_b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          lfsr_d  = SEED;
          idx_d   = 16'd0;
          dut_a_d = SEED[7:0];
          dut_b_d = SEED[15:8];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 8'd0;
          fail_d  = NO_FAIL;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        state_d  = ST_WAIT;
        settle_d = 4'd0;
      end
      ST_WAIT: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = err_q;
          end
          if (fail_q == NO_FAIL) begin
            fail_d = idx_q;
          end else begin
            fail_d = fail_q;
          end
        end else begin
          err_d = err_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 8'd0) && !mismatch_s;
          dut_a_d = 8'h00;
          dut_b_d = 8'h00;
        end else begin
          // Operands for the next vector are loaded as the FSM re-enters APPLY.
          state_d = ST_APPLY;
          lfsr_d  = lfsr_next_s;
          idx_d   = idx_q + 16'd1;
          dut_a_d = lfsr_next_s[7:0];
          dut_b_d = lfsr_next_s[15:8];
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        dut_a_d = 8'h00;
        dut_b_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED;
      idx_q    <= 16'd0;
      settle_q <= 4'd0;
      dut_a_q  <= 8'h00;
      dut_b_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 8'd0;
      fail_q   <= NO_FAIL;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      dut_a_q  <= dut_a_d;
      dut_b_q  <= dut_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fail_q;

endmodule
